mac_operand_splitter: RTL and testbench

- Front end of the reconfigurable MAC array; the opposite direction of the partial-product combiner.
- Accepts one wide operand pair plus a mode and slices it into MAC_MIN_WIDTH operand bytes for the four MAC units.
- Sequences multi-beat issue in dual (16b) and quad (32b) modes so downstream accumulators and the combiner see aligned partials.
- Valid/ready handshakes on both sides.

---
 rtl/mac_operand_splitter_pkg.sv | 30 +++
 rtl/mac_operand_splitter_slice_mux.sv | 72 +++++++
 rtl/mac_operand_splitter.sv | 127 ++++++++++++
 tb/tb_mac_operand_splitter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_operand_splitter_pkg.sv
// Shared constants for the MAC operand splitter: mode encodings, last-beat
// indices per mode and the issue FSM state encoding.
package mac_operand_splitter_pkg;

    localparam logic [1:0] MAC_MODE_SINGLE = 2'b00;
    localparam logic [1:0] MAC_MODE_DUAL   = 2'b01;
    localparam logic [1:0] MAC_MODE_QUAD   = 2'b10;
    localparam logic [1:0] MAC_MODE_RSVD   = 2'b11;

    // Index of the final beat (beats per mode minus one)
    localparam logic [1:0] MAC_LAST_SINGLE = 2'd0;
    localparam logic [1:0] MAC_LAST_DUAL   = 2'd1;
    localparam logic [1:0] MAC_LAST_QUAD   = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } mac_state_t;

    function automatic logic [1:0] mac_last_beat(input logic [1:0] mode);
        logic [1:0] idx;
        case (mode)
            MAC_MODE_DUAL: idx = MAC_LAST_DUAL;
            MAC_MODE_QUAD: idx = MAC_LAST_QUAD;
            default:       idx = MAC_LAST_SINGLE;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mac_operand_splitter_slice_mux.sv
// Combinational slice map: picks the A/B operand bytes presented to each of
// the four MAC units for the current mode and beat.
module mac_operand_splitter_slice_mux
    import mac_operand_splitter_pkg::*;
#(
    parameter int MIN_W = 8
) (
    input  logic [1:0]         i_mode,
    input  logic [1:0]         i_beat,
    input  logic [4*MIN_W-1:0] i_op_a,
    input  logic [4*MIN_W-1:0] i_op_b,
    output logic [MIN_W-1:0]   o_a0,
    output logic [MIN_W-1:0]   o_a1,
    output logic [MIN_W-1:0]   o_a2,
    output logic [MIN_W-1:0]   o_a3,
    output logic [MIN_W-1:0]   o_b0,
    output logic [MIN_W-1:0]   o_b1,
    output logic [MIN_W-1:0]   o_b2,
    output logic [MIN_W-1:0]   o_b3,
    output logic               o_last
);

    function automatic logic [MIN_W-1:0] byte_of(input logic [4*MIN_W-1:0] x,
                                                 input logic [1:0] idx);
        logic [MIN_W-1:0] r;
        case (idx)
            2'd0:    r = x[0*MIN_W +: MIN_W];
            2'd1:    r = x[1*MIN_W +: MIN_W];
            2'd2:    r = x[2*MIN_W +: MIN_W];
            2'd3:    r = x[3*MIN_W +: MIN_W];
            default: r = x[0*MIN_W +: MIN_W];
        endcase
        return r;
    endfunction

    logic [1:0] w_hi_idx;
    assign w_hi_idx = i_beat + 2'd2;
    assign o_last   = (i_beat == mac_last_beat(i_mode));

    // A is always lane-aligned; B broadcasts one byte per beat in wide modes
    always_comb begin
        o_a0 = byte_of(i_op_a, 2'd0);
        o_a1 = byte_of(i_op_a, 2'd1);
        o_a2 = byte_of(i_op_a, 2'd2);
        o_a3 = byte_of(i_op_a, 2'd3);
        o_b0 = byte_of(i_op_b, 2'd0);
        o_b1 = byte_of(i_op_b, 2'd1);
        o_b2 = byte_of(i_op_b, 2'd2);
        o_b3 = byte_of(i_op_b, 2'd3);
        case (i_mode)
            MAC_MODE_DUAL: begin
                o_b0 = byte_of(i_op_b, i_beat);
                o_b1 = byte_of(i_op_b, i_beat);
                o_b2 = byte_of(i_op_b, w_hi_idx);
                o_b3 = byte_of(i_op_b, w_hi_idx);
            end
            MAC_MODE_QUAD: begin
                o_b0 = byte_of(i_op_b, i_beat);
                o_b1 = byte_of(i_op_b, i_beat);
                o_b2 = byte_of(i_op_b, i_beat);
                o_b3 = byte_of(i_op_b, i_beat);
            end
            default: begin
                o_b0 = byte_of(i_op_b, 2'd0);
                o_b1 = byte_of(i_op_b, 2'd1);
                o_b2 = byte_of(i_op_b, 2'd2);
                o_b3 = byte_of(i_op_b, 2'd3);
            end
        endcase
    end

endmodule

// File: rtl/mac_operand_splitter.sv
// MAC operand splitter: captures a wide operand pair and issues 1/2/4 slice beats.
// Optional stall counter output enabled by `define MAC_SPLIT_PERF_CNT_EN.
module mac_operand_splitter
    import mac_operand_splitter_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [MAC_CONF_WIDTH-1:0] cfg,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAC_ACC_WIDTH-1:0]  in_a,
    input  logic [MAC_ACC_WIDTH-1:0]  in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAC_MIN_WIDTH-1:0]  out_a0,
    output logic [MAC_MIN_WIDTH-1:0]  out_a1,
    output logic [MAC_MIN_WIDTH-1:0]  out_a2,
    output logic [MAC_MIN_WIDTH-1:0]  out_a3,
    output logic [MAC_MIN_WIDTH-1:0]  out_b0,
    output logic [MAC_MIN_WIDTH-1:0]  out_b1,
    output logic [MAC_MIN_WIDTH-1:0]  out_b2,
    output logic [MAC_MIN_WIDTH-1:0]  out_b3,
    output logic [1:0]                out_beat,
    output logic                      out_first,
    output logic                      out_last,
    output logic                      cfg_err
`ifdef MAC_SPLIT_PERF_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    mac_state_t               r_state;
    logic [MAC_ACC_WIDTH-1:0] r_a;
    logic [MAC_ACC_WIDTH-1:0] r_b;
    logic [1:0]               r_mode;
    logic [1:0]               r_beat;
    logic                     r_out_valid;
    logic                     r_cfg_err;
    logic                     w_last;
    logic                     w_in_xfer;
    logic                     w_out_xfer;
    logic                     w_cfg_unused;

    assign w_cfg_unused = ^cfg[MAC_CONF_WIDTH-1:2];

    // Ready while idle or when the final beat leaves this cycle (no bubble)
    assign in_ready   = ~rst & en & ((r_state == ST_IDLE) | (r_out_valid & out_ready & w_last));
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_out_valid & out_ready & en;

    assign out_valid = r_out_valid;
    assign out_beat  = r_beat;
    assign out_first = (r_beat == 2'd0);
    assign out_last  = w_last;
    assign cfg_err   = r_cfg_err;

    mac_operand_splitter_slice_mux #(
        .MIN_W (MAC_MIN_WIDTH)
    ) u_slice_mux (
        .i_mode (r_mode),
        .i_beat (r_beat),
        .i_op_a (r_a),
        .i_op_b (r_b),
        .o_a0   (out_a0),
        .o_a1   (out_a1),
        .o_a2   (out_a2),
        .o_a3   (out_a3),
        .o_b0   (out_b0),
        .o_b1   (out_b1),
        .o_b2   (out_b2),
        .o_b3   (out_b3),
        .o_last (w_last)
    );

    // Issue FSM with operand capture and beat sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= MAC_MODE_SINGLE;
            r_beat      <= 2'd0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else if (en) begin
            if (w_in_xfer) begin
                r_state     <= ST_ISSUE;
                r_a         <= in_a;
                r_b         <= in_b;
                r_mode      <= cfg[1:0];
                r_beat      <= 2'd0;
                r_out_valid <= 1'b1;
                r_cfg_err   <= r_cfg_err | (cfg[1:0] == MAC_MODE_RSVD);
            end else if (w_out_xfer) begin
                if (w_last) begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_beat      <= 2'd0;
                end else begin
                    r_beat <= r_beat + 2'd1;
                end
            end
        end
    end

`ifdef MAC_SPLIT_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles where a beat waits on the MAC units
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (en & r_out_valid & ~out_ready & (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mac_operand_splitter.sv
// Self-checking bench for mac_operand_splitter: directed scenarios plus random
// traffic against a beat-queue reference model.
module tb_mac_operand_splitter;

    logic        clk = 1'b0;
    logic        rst, en, in_valid, out_ready;
    logic [2:0]  cfg;
    logic [31:0] in_a, in_b;
    logic        in_ready, out_valid, out_first, out_last, cfg_err;
    logic [7:0]  out_a0, out_a1, out_a2, out_a3, out_b0, out_b1, out_b2, out_b3;
    logic [1:0]  out_beat;
`ifdef MAC_SPLIT_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    mac_operand_splitter dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg       (cfg),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a0    (out_a0),
        .out_a1    (out_a1),
        .out_a2    (out_a2),
        .out_a3    (out_a3),
        .out_b0    (out_b0),
        .out_b1    (out_b1),
        .out_b2    (out_b2),
        .out_b3    (out_b3),
        .out_beat  (out_beat),
        .out_first (out_first),
        .out_last  (out_last),
        .cfg_err   (cfg_err)
`ifdef MAC_SPLIT_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct packed {
        logic [63:0] sl;
        logic [1:0]  k;
        logic        last;
    } beat_t;

    beat_t       q[$];
    logic        m_err;
    int unsigned m_stall;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] slices();
        return {out_b3, out_b2, out_b1, out_b0, out_a3, out_a2, out_a1, out_a0};
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] x, input int i);
        return x[i*8 +: 8];
    endfunction

    // Expand one accepted operation into its list of expected beats
    task automatic push_op(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b);
        int n;
        int bi;
        beat_t t;
        n = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (mode == 2'b01)      bi = (j / 2) * 2 + k;
                else if (mode == 2'b10) bi = k;
                else                    bi = j;
                t.sl[j*8 +: 8]      = byte_at(a, j);
                t.sl[32 + j*8 +: 8] = byte_at(b, bi);
            end
            t.k    = 2'(k);
            t.last = (k == n - 1);
            q.push_back(t);
        end
        if (mode == 2'b11) m_err = 1'b1;
    endtask

    task automatic cycle(input logic iv, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy, input logic e);
        logic  exp_rdy;
        logic  has;
        beat_t hd;
        @(negedge clk);
        in_valid = iv; cfg = c; in_a = a; in_b = b; out_ready = ordy; en = e;
        #1;
        has = (q.size() != 0);
        hd  = has ? q[0] : '0;
        exp_rdy = e && (!has || (ordy && hd.last));
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(has));
        if (has) begin
            check("slices", slices(), hd.sl);
            check("beat", 64'(out_beat), 64'(hd.k));
            check("first", 64'(out_first), 64'(hd.k == 2'd0));
            check("last", 64'(out_last), 64'(hd.last));
        end
        check("cfg_err", 64'(cfg_err), 64'(m_err));
`ifdef MAC_SPLIT_PERF_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        if (e && has && !ordy) m_stall++;
        if (e && has && ordy) void'(q.pop_front());
        if (iv && exp_rdy) push_op(c[1:0], a, b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        q.delete();
        m_err = 1'b0;
        m_stall = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int vcnt;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cfg = 3'd0; in_a = 32'd0; in_b = 32'd0;
        m_err = 1'b0; m_stall = 0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_beat", 64'(out_beat), 64'd0);
        check("reset_cfg_err", 64'(cfg_err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single
        cycle(1'b1, 3'b000, 32'h0403_0201, 32'h0807_0605, 1'b1, 1'b1);
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);
        check("single_slices", slices(), 64'h0807_0605_0403_0201);
        check("single_first_last", {62'd0, out_first, out_last}, 64'd3);

        // quad with 3-cycle stall at k=1
        cycle(1'b1, 3'b010, 32'h0403_0201, 32'h0807_0605, 1'b1, 1'b1);
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("quad_k1_slices", slices(), 64'h0606_0606_0403_0201);
        repeat (3) cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);
        check("quad_k3_last", {62'd0, out_beat}, 64'd3);
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);
`ifdef MAC_SPLIT_PERF_CNT_EN
        check("quad_stall3", 64'(stall_cnt), 64'd3);
`endif

        // dual
        cycle(1'b1, 3'b001, 32'hDDCC_1234, 32'h7788_AABB, 1'b1, 1'b1);
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);
        check("dual_k0", slices(), 64'h8888_BBBB_DDCC_1234);
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);
        check("dual_k1", slices(), 64'h7777_AAAA_DDCC_1234);
        check("dual_k1_last", 64'(out_last), 64'd1);

        // back-to-back quads
        vcnt = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 3'b010, 32'h1111_1111 * (i + 1), 32'h0101_0101 * (i + 3), 1'b1, 1'b1);
            if (i > 0 && out_valid) vcnt++;
        end
        check("b2b_beats", 64'(vcnt), 64'd8);
        repeat (5) cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);

        // reset at quad k=2
        cycle(1'b1, 3'b010, 32'hA1A2_A3A4, 32'hB1B2_B3B4, 1'b1, 1'b1);
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1);
        check("rst_at_k2", 64'(out_beat), 64'd2);
        do_reset();
        repeat (2) cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);

        // en low mid-dual
        cycle(1'b1, 3'b001, 32'h5566_7788, 32'h99AA_BBCC, 1'b1, 1'b1);
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1);
        repeat (2) cycle(1'b1, 3'b010, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0);
        check("en_low_beat", 64'(out_beat), 64'd0);
        repeat (3) cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);

        // reserved mode
        cycle(1'b1, 3'b011, 32'h0403_0201, 32'h0807_0605, 1'b1, 1'b1);
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);
        check("rsvd_single", slices(), 64'h0807_0605_0403_0201);
        check("rsvd_err", 64'(cfg_err), 64'd1);
        cycle(1'b1, 3'b000, 32'h1, 32'h2, 1'b1, 1'b1);
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);
        check("rsvd_err_sticky", 64'(cfg_err), 64'd1);
        do_reset();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) != 0));
        end
        do_reset();
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
